// File: rtl/reg_file_sb.sv
// reg_file_sb: two-read / one-write register file with a per-register busy
// scoreboard. The top register is hard-wired to zero. A two-state FSM zeroes
// the whole array after reset or on request. Writes and reserves are accepted
// only while idle.
module reg_file_sb #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 32,
  parameter int AW     = $clog2(DEPTH),
  parameter int BYPASS = 1
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic [AW-1:0]    RA,
  input  logic [AW-1:0]    RB,
  output logic [WIDTH-1:0] BusA,
  output logic [WIDTH-1:0] BusB,
  input  logic [AW-1:0]    RW,
  input  logic [WIDTH-1:0] BusW,
  input  logic             RegWr,
  input  logic             Reserve,
  input  logic [AW-1:0]    ResvAddr,
  output logic             BusyA,
  output logic             BusyB,
  input  logic             Clear,
  output logic             Ready
);

  localparam logic [AW-1:0] ZREG = AW'(DEPTH - 1);
  localparam bit            BYP  = (BYPASS != 0);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             idle;
  logic             wr_en;
  logic             rsv_en;

  // A Clear request in the same cycle wins over a write or reserve, and the
  // zero register never accepts either.
  assign idle   = (state == IDLE);
  assign wr_en  = idle && RegWr   && !Clear && (RW       != ZREG);
  assign rsv_en = idle && Reserve && !Clear && (ResvAddr != ZREG);

  // FSM state and zeroing counter; reset drops straight into the clear sweep.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: one sweep of DEPTH cycles, restarted by Clear, never wrapping.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (Clear) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        if (Clear) begin
          cnt_nxt = '0;
        end else if (cnt == ZREG) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      default: begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Scoreboard bits: the reserve is applied after the write-clear, so a
  // reserve and a write to the same register leave it busy.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      busy <= '0;
    end else if (!idle || Clear) begin
      busy <= '0;
    end else begin
      if (wr_en)  busy[RW]       <= 1'b0;
      if (rsv_en) busy[ResvAddr] <= 1'b1;
    end
  end

  // Register storage carries no reset; the clear sweep zeroes one entry per cycle.
  always_ff @(posedge Clk) begin
    if (state == CLEAR) begin
      regs[cnt] <= '0;
    end else if (wr_en) begin
      regs[RW] <= BusW;
    end
  end

  // Outputs: reads are masked to zero outside IDLE and for the zero register;
  // busy flags reflect stored state only.
  always_comb begin
    Ready = idle;
    BusA  = '0;
    BusB  = '0;
    BusyA = 1'b0;
    BusyB = 1'b0;
    if (idle) begin
      if (RA != ZREG) begin
        if (BYP && wr_en && (RW == RA)) BusA = BusW;
        else                            BusA = regs[RA];
      end
      if (RB != ZREG) begin
        if (BYP && wr_en && (RW == RB)) BusB = BusW;
        else                            BusB = regs[RB];
      end
      BusyA = busy[RA];
      BusyB = busy[RB];
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed bench for reg_file_sb. Two instances share every
// input: u_byp (BYPASS=1) and u_nb (BYPASS=0).
module tb_reg_file_sb;

  localparam int WIDTH = 64;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic             Clk = 1'b0;
  logic             ResetN;
  logic [AW-1:0]    RA, RB, RW, ResvAddr;
  logic [WIDTH-1:0] BusW;
  logic             RegWr, Reserve, Clear;

  logic [WIDTH-1:0] BusA1, BusB1, BusA0, BusB0;
  logic             BusyA1, BusyB1, BusyA0, BusyB0;
  logic             Ready1, Ready0;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  reg_file_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(1)) u_byp (
    .Clk(Clk), .ResetN(ResetN), .RA(RA), .RB(RB), .BusA(BusA1), .BusB(BusB1),
    .RW(RW), .BusW(BusW), .RegWr(RegWr), .Reserve(Reserve), .ResvAddr(ResvAddr),
    .BusyA(BusyA1), .BusyB(BusyB1), .Clear(Clear), .Ready(Ready1)
  );

  reg_file_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(0)) u_nb (
    .Clk(Clk), .ResetN(ResetN), .RA(RA), .RB(RB), .BusA(BusA0), .BusB(BusB0),
    .RW(RW), .BusW(BusW), .RegWr(RegWr), .Reserve(Reserve), .ResvAddr(ResvAddr),
    .BusyA(BusyA0), .BusyB(BusyB0), .Clear(Clear), .Ready(Ready0)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    ResetN = 1'b1;
    #3;
    ResetN = 1'b0;
    #1;
    total++; if (Ready1 !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", Ready1); end
    total++; if (BusA1 !== 64'd0) begin bad++; $display("FAIL reset_busa got=%h want=0", BusA1); end
    total++; if (BusyA1 !== 1'b0) begin bad++; $display("FAIL reset_busya got=%b want=0", BusyA1); end
    tick();
    ResetN = 1'b1;
    n = 0;
    while (Ready1 !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    total++; if (n != 32) begin bad++; $display("FAIL reset_clear_len got=%0d want=32", n); end
    total++; if (Ready0 !== 1'b1) begin bad++; $display("FAIL reset_ready_nb got=%b want=1", Ready0); end
    for (int i = 0; i < DEPTH; i++) begin
      RA = AW'(i);
      #1;
      total++;
      if (BusA1 !== 64'd0 || BusA0 !== 64'd0) begin
        bad++; $display("FAIL reset_read r%0d got=%h/%h want=0", i, BusA1, BusA0);
      end
    end
  endtask

  task automatic test_bypass();
    logic [WIDTH-1:0] v;
    v = 64'hDEADBEEF_00000001;
    tick();
    RW = 5'd4; BusW = v; RegWr = 1'b1; RA = 5'd4;
    #1;
    total++; if (BusA1 !== v) begin bad++; $display("FAIL bypass_same got=%h want=%h", BusA1, v); end
    total++; if (BusA0 !== 64'd0) begin bad++; $display("FAIL nobypass_old got=%h want=0", BusA0); end
    tick();
    RegWr = 1'b0;
    #1;
    total++; if (BusA0 !== v) begin bad++; $display("FAIL nobypass_next got=%h want=%h", BusA0, v); end
    total++; if (BusA1 !== v) begin bad++; $display("FAIL bypass_next got=%h want=%h", BusA1, v); end
  endtask

  task automatic test_zero_reg();
    RW = 5'd31; BusW = '1; RegWr = 1'b1; Reserve = 1'b1; ResvAddr = 5'd31; RA = 5'd31;
    #1;
    total++; if (BusA1 !== 64'd0) begin bad++; $display("FAIL zreg_bypass got=%h want=0", BusA1); end
    tick();
    RegWr = 1'b0; Reserve = 1'b0;
    #1;
    total++; if (BusA1 !== 64'd0 || BusA0 !== 64'd0) begin bad++; $display("FAIL zreg_read got=%h/%h want=0", BusA1, BusA0); end
    total++; if (BusyA1 !== 1'b0) begin bad++; $display("FAIL zreg_busy got=%b want=0", BusyA1); end
  endtask

  task automatic test_scoreboard();
    Reserve = 1'b1; ResvAddr = 5'd12; RA = 5'd12; RB = 5'd12;
    #1;
    total++; if (BusyA1 !== 1'b0) begin bad++; $display("FAIL sb_no_fwd got=%b want=0", BusyA1); end
    tick();
    Reserve = 1'b0;
    #1;
    total++; if (BusyA1 !== 1'b1) begin bad++; $display("FAIL sb_reserved got=%b want=1", BusyA1); end
    total++; if (BusyB0 !== 1'b1) begin bad++; $display("FAIL sb_reserved_b got=%b want=1", BusyB0); end
    RW = 5'd12; BusW = 64'd5; RegWr = 1'b1;
    #1;
    total++; if (BusA1 !== 64'd5) begin bad++; $display("FAIL sb_wr_bypass got=%h want=5", BusA1); end
    total++; if (BusyA1 !== 1'b1) begin bad++; $display("FAIL sb_busy_during_wr got=%b want=1", BusyA1); end
    tick();
    RegWr = 1'b0;
    #1;
    total++; if (BusyA1 !== 1'b0) begin bad++; $display("FAIL sb_wr_clears got=%b want=0", BusyA1); end
    total++; if (BusA0 !== 64'd5) begin bad++; $display("FAIL sb_wr_data got=%h want=5", BusA0); end
    RegWr = 1'b1; BusW = 64'd7; Reserve = 1'b1; ResvAddr = 5'd12;
    tick();
    RegWr = 1'b0; Reserve = 1'b0;
    #1;
    total++; if (BusyA1 !== 1'b1 || BusyB1 !== 1'b1) begin bad++; $display("FAIL sb_resv_wins got=%b%b want=11", BusyA1, BusyB1); end
    total++; if (BusA0 !== 64'd7) begin bad++; $display("FAIL sb_resv_wr_data got=%h want=7", BusA0); end
  endtask

  task automatic test_back_to_back();
    RA = 5'd9; RW = 5'd9; RegWr = 1'b1; BusW = 64'hAAAA;
    tick();
    BusW = 64'hBBBB;
    #1;
    total++; if (BusA1 !== 64'hBBBB) begin bad++; $display("FAIL b2b_bypass got=%h want=bbbb", BusA1); end
    total++; if (BusA0 !== 64'hAAAA) begin bad++; $display("FAIL b2b_old got=%h want=aaaa", BusA0); end
    tick();
    RegWr = 1'b0;
    #1;
    total++; if (BusA0 !== 64'hBBBB) begin bad++; $display("FAIL b2b_final got=%h want=bbbb", BusA0); end
  endtask

  task automatic test_clear_restart();
    int low;
    for (int i = 0; i < DEPTH - 1; i++) begin
      RW = AW'(i); BusW = 64'(i + 'h100); RegWr = 1'b1;
      tick();
    end
    RegWr = 1'b0; RA = 5'd7; RB = 5'd30;
    #1;
    total++; if (BusA0 !== 64'h107) begin bad++; $display("FAIL fill_r7 got=%h want=107", BusA0); end
    total++; if (BusB1 !== 64'h11E) begin bad++; $display("FAIL fill_r30 got=%h want=11e", BusB1); end
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    RegWr = 1'b1; RW = 5'd5; BusW = 64'h99; Reserve = 1'b1; ResvAddr = 5'd6;
    RA = 5'd5; RB = 5'd6;
    low = 0;
    for (int k = 1; k <= 10; k++) begin
      Clear = (k == 10);
      #1;
      total++;
      if (Ready1 !== 1'b0 || BusA1 !== 64'd0 || BusyB1 !== 1'b0) begin
        bad++; $display("FAIL clear_cycle%0d got rdy=%b a=%h by=%b want 0/0/0", k, Ready1, BusA1, BusyB1);
      end
      if (Ready1 === 1'b0) low++;
      tick();
    end
    Clear = 1'b0;
    while (Ready1 !== 1'b1 && low < 200) begin
      low++;
      tick();
    end
    RegWr = 1'b0; Reserve = 1'b0;
    #1;
    total++; if (low != 42) begin bad++; $display("FAIL clear_restart_len got=%0d want=42", low); end
    total++; if (BusyB1 !== 1'b0) begin bad++; $display("FAIL clear_resv_dropped got=%b want=0", BusyB1); end
    total++; if (Ready0 !== 1'b1) begin bad++; $display("FAIL clear_ready_nb got=%b want=1", Ready0); end
    for (int i = 0; i < DEPTH; i++) begin
      RA = AW'(i);
      #1;
      total++;
      if (BusA1 !== 64'd0 || BusA0 !== 64'd0) begin
        bad++; $display("FAIL clear_read r%0d got=%h/%h want=0", i, BusA1, BusA0);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    tick();
    RegWr = 1'b1; RW = 5'd2; BusW = 64'h22; Reserve = 1'b1; ResvAddr = 5'd3;
    tick();
    RegWr = 1'b0; Reserve = 1'b0; RA = 5'd3; RB = 5'd2;
    #1;
    total++; if (BusyA1 !== 1'b1) begin bad++; $display("FAIL rmid_pre_busy got=%b want=1", BusyA1); end
    total++; if (BusB1 !== 64'h22) begin bad++; $display("FAIL rmid_pre_data got=%h want=22", BusB1); end
    #2;
    ResetN = 1'b0;
    #1;
    total++; if (BusyA1 !== 1'b0) begin bad++; $display("FAIL rmid_async_busy got=%b want=0", BusyA1); end
    total++; if (BusB1 !== 64'd0 || BusB0 !== 64'd0) begin bad++; $display("FAIL rmid_async_bus got=%h/%h want=0", BusB1, BusB0); end
    total++; if (Ready1 !== 1'b0) begin bad++; $display("FAIL rmid_async_ready got=%b want=0", Ready1); end
    tick();
    ResetN = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    #2;
    ResetN = 1'b0;
    #1;
    total++; if (Ready1 !== 1'b0 || BusyA1 !== 1'b0) begin bad++; $display("FAIL rmid_clear_reset got=%b%b want=00", Ready1, BusyA1); end
    tick();
    ResetN = 1'b1;
    n = 0;
    while (Ready1 !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    total++; if (n != 32) begin bad++; $display("FAIL rmid_clear_len got=%0d want=32", n); end
    total++; if (BusB1 !== 64'd0 || BusyA1 !== 1'b0) begin bad++; $display("FAIL rmid_after got=%h/%b want=0/0", BusB1, BusyA1); end
  endtask

  initial begin
    ResetN = 1'b1; RA = '0; RB = '0; RW = '0; ResvAddr = '0;
    BusW = '0; RegWr = 1'b0; Reserve = 1'b0; Clear = 1'b0;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_back_to_back();
    test_clear_restart();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
